// File: rtl/mux_4to1_80bit_arb.sv
// Round-robin arbiter steering an external 4:1 mux, with a valid/ready
// output register that captures the selected mux word.
module mux_4to1_80bit_arb #(
  parameter int WIDTH = 80
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [3:0]       Req,
  output logic [3:0]       Grant,
  output logic [1:0]       Select,
  input  logic [WIDTH-1:0] MuxData,
  output logic [WIDTH-1:0] OutData,
  output logic             OutValid,
  input  logic             OutReady
);

  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       any_req;
  logic       load;
  logic       take;

  // Rotating priority: scan last+1 .. last+4; with no request the
  // winner stays at last so the mux select does not move.
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    idx     = last;
    for (int k = 1; k < 5; k++) begin
      idx = last + 2'(k);
      if (!any_req && Req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign load = ~OutValid | OutReady;
  assign take = any_req & load;

  // Outputs are forced to their idle values while reset is held so a
  // source never sees a grant during reset.
  assign Grant  = (take && Reset_n) ? (4'b0001 << winner) : 4'b0000;
  assign Select = Reset_n ? winner : 2'b11;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last     <= 2'b11;
      OutValid <= 1'b0;
      OutData  <= '0;
    end else if (take) begin
      last     <= winner;
      OutValid <= 1'b1;
      OutData  <= MuxData;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4to1_80bit_arb.sv
// Directed table-driven bench for mux_4to1_80bit_arb with a behavioural
// 4:1 mux feeding MuxData from the DUT's Select.
module tb_mux_4to1_80bit_arb;

  localparam int W = 80;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic [W-1:0] mux_data;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] in_w [4];

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [3:0]   req;
    logic         rdy;
    logic [W-1:0] in2;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] data;
  } vec_t;

  vec_t vq[$];

  localparam logic [W-1:0] BIG2 = 80'hF000_0000_0000_0000_0033;

  mux_4to1_80bit_arb #(.WIDTH(W)) dut (
    .Clock(clk), .Reset_n(rst_n), .Req(req), .Grant(grant), .Select(sel),
    .MuxData(mux_data), .OutData(out_data), .OutValid(out_valid),
    .OutReady(out_ready)
  );

  assign mux_data = in_w[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: act=%h exp=%h", name, act, exp);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    in_w[0] = 80'h1; in_w[1] = 80'h2; in_w[2] = 80'h3; in_w[3] = 80'h4;

    // idle after reset
    vq.push_back('{4'b0000, 1'b0, 80'h3, 4'b0000, 2'b11, 1'b0, 80'h0});
    vq.push_back('{4'b0000, 1'b0, 80'h3, 4'b0000, 2'b11, 1'b0, 80'h0});
    vq.push_back('{4'b0000, 1'b0, 80'h3, 4'b0000, 2'b11, 1'b0, 80'h0});
    // full rotation at one word per cycle
    vq.push_back('{4'b1111, 1'b1, 80'h3, 4'b0001, 2'b00, 1'b1, 80'h1});
    vq.push_back('{4'b1111, 1'b1, 80'h3, 4'b0010, 2'b01, 1'b1, 80'h2});
    vq.push_back('{4'b1111, 1'b1, 80'h3, 4'b0100, 2'b10, 1'b1, 80'h3});
    vq.push_back('{4'b1111, 1'b1, 80'h3, 4'b1000, 2'b11, 1'b1, 80'h4});
    vq.push_back('{4'b1111, 1'b1, 80'h3, 4'b0001, 2'b00, 1'b1, 80'h1});
    // drain with no requests: data held, select parks at last
    vq.push_back('{4'b0000, 1'b1, 80'h3, 4'b0000, 2'b00, 1'b0, 80'h1});
    // backpressure on source 2, then drain+reload in one edge
    vq.push_back('{4'b0100, 1'b0, 80'h3, 4'b0100, 2'b10, 1'b1, 80'h3});
    vq.push_back('{4'b0100, 1'b0, 80'h3, 4'b0000, 2'b10, 1'b1, 80'h3});
    vq.push_back('{4'b0100, 1'b0, 80'h3, 4'b0000, 2'b10, 1'b1, 80'h3});
    vq.push_back('{4'b0100, 1'b1, BIG2,  4'b0100, 2'b10, 1'b1, BIG2});
    vq.push_back('{4'b0000, 1'b1, BIG2,  4'b0000, 2'b10, 1'b0, BIG2});
    // move last to 1, then Req=0011 wins 0 then 1
    vq.push_back('{4'b0010, 1'b1, 80'h3, 4'b0010, 2'b01, 1'b1, 80'h2});
    vq.push_back('{4'b0011, 1'b1, 80'h3, 4'b0001, 2'b00, 1'b1, 80'h1});
    vq.push_back('{4'b0011, 1'b1, 80'h3, 4'b0010, 2'b01, 1'b1, 80'h2});
    vq.push_back('{4'b0000, 1'b1, 80'h3, 4'b0000, 2'b01, 1'b0, 80'h2});

    #12;
    chk("rst_valid",  {79'd0, out_valid}, 80'd0);
    chk("rst_data",   out_data, 80'd0);
    chk("rst_sel",    {78'd0, sel}, {78'd0, 2'b11});
    chk("rst_grant",  {76'd0, grant}, 80'd0);

    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      req = vq[i].req; out_ready = vq[i].rdy; in_w[2] = vq[i].in2;
      #1;
      chk($sformatf("v%0d_grant", i), {76'd0, grant}, {76'd0, vq[i].grant});
      chk($sformatf("v%0d_sel", i),   {78'd0, sel},   {78'd0, vq[i].sel});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {79'd0, out_valid}, {79'd0, vq[i].valid});
      chk($sformatf("v%0d_data", i),  out_data, vq[i].data);
    end

    // capture from source 3 under backpressure, then async reset mid-stream
    @(negedge clk);
    req = 4'b1000; out_ready = 1'b0;
    #1;
    chk("pre_grant", {76'd0, grant}, {76'd0, 4'b1000});
    @(posedge clk); #1;
    chk("pre_valid", {79'd0, out_valid}, 80'd1);
    chk("pre_data",  out_data, 80'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {79'd0, out_valid}, 80'd0);
    chk("arst_data",  out_data, 80'd0);
    chk("arst_grant", {76'd0, grant}, 80'd0);
    chk("arst_sel",   {78'd0, sel}, {78'd0, 2'b11});
    @(posedge clk); #1;
    chk("arst_hold_valid", {79'd0, out_valid}, 80'd0);
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0110; out_ready = 1'b1;
    #1;
    chk("post_grant", {76'd0, grant}, {76'd0, 4'b0010});
    chk("post_sel",   {78'd0, sel}, {78'd0, 2'b01});
    @(posedge clk); #1;
    chk("post_valid", {79'd0, out_valid}, 80'd1);
    chk("post_data",  out_data, 80'h2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
